// File: rtl/disk_ctrl.sv
// disk_ctrl: moves whole 512-word sectors between a local buffer and a word-addressed
// backing store; commands come from rising edges of the disk bus-slave pause strobes.
module disk_ctrl #(
    parameter int STORE_AW     = 32,
    parameter int QUIET_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         instruction,
    input  logic                write_pause,
    input  logic                read_pause,
    input  logic [8:0]          disk_addr,
    input  logic [31:0]         disk_data_out,
    input  logic                buf_we,
    output logic [31:0]         disk_data_in,
    output logic                disk_operate_done,
    output logic                busy,
    output logic                store_req,
    output logic                store_we,
    output logic [STORE_AW-1:0] store_addr,
    output logic [31:0]         store_wdata,
    input  logic [31:0]         store_rdata,
    input  logic                store_ack
);
    localparam int LW = STORE_AW - 9;
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state_q, state_d;
    logic          wp_q, rp_q, dir_q, dir_d;
    logic [LW-1:0] lba_q, lba_d;
    logic [8:0]    idx_q, idx_d;
    logic [QW-1:0] quiet_q, quiet_d;
    logic [31:0]   mem [512];
    logic          start_w, start, xfer, unused_bits;

    assign start_w     = write_pause & ~wp_q;
    assign start       = (start_w | (read_pause & ~rp_q)) & instruction[30];
    assign xfer        = state_q == XFER;
    assign unused_bits = ^{instruction[31], instruction[29:LW]};

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        lba_d   = lba_q;
        idx_d   = idx_q;
        quiet_d = '0;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = XFER;
                dir_d   = start_w;
                lba_d   = instruction[LW-1:0];
                idx_d   = '0;
            end
            XFER: if (store_ack) begin
                idx_d = idx_q + 9'd1;
                if (idx_q == 9'd511) state_d = DONE;
            end
            DONE: begin
                // any pause activity restarts the quiet window
                quiet_d = (write_pause | read_pause) ? '0 : quiet_q + 1'b1;
                if (quiet_d == QW'(QUIET_CYCLES)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            dir_q   <= 1'b0;
            lba_q   <= '0;
            idx_q   <= '0;
            quiet_q <= '0;
        end else begin
            state_q <= state_d;
            wp_q    <= write_pause;
            rp_q    <= read_pause;
            dir_q   <= dir_d;
            lba_q   <= lba_d;
            idx_q   <= idx_d;
            quiet_q <= quiet_d;
        end
    end

    // single write port: the engine owns it during a read command, the bus only in IDLE
    always_ff @(posedge clk) begin
        if (xfer && store_ack && !dir_q) mem[idx_q] <= store_rdata;
        else if (state_q == IDLE && buf_we) mem[disk_addr] <= disk_data_out;
    end

    assign disk_data_in      = mem[disk_addr];
    assign store_wdata       = mem[idx_q];
    assign store_req         = xfer;
    assign store_we          = xfer & dir_q;
    assign store_addr        = {lba_q, idx_q};
    assign busy              = state_q != IDLE;
    assign disk_operate_done = state_q == DONE;
endmodule
